// File: rtl/zbus_dma_target_if.sv
// zbus_dma_target_if: 68000-side bus pins and local memory request port
// of the external-master DMA target, bundled for one connection.
// The slave modport is the target's view, the master modport is the
// driver of the Amiga bus and local memory controller.
interface zbus_dma_target_if;
  // Amiga 68000 bus inputs (strobes active low, asynchronous)
  logic        AS;
  logic        UDS;
  logic        LDS;
  logic        RW;
  logic [23:1] A;
  logic        BGACK;
  // Local memory controller
  logic        MEM_ACK;
  logic        MEM_REQ;
  logic        MEM_RW;
  logic [1:0]  MEM_BE;
  logic [23:1] MEM_ADDR;
  // Bus response
  logic        DATA_OE;
  logic        DTACK_O;
  logic        DTACK_OE;
  logic        BERR_N;

  modport slave (
    input  AS, UDS, LDS, RW, A, BGACK, MEM_ACK,
    output MEM_REQ, MEM_RW, MEM_BE, MEM_ADDR, DATA_OE, DTACK_O, DTACK_OE, BERR_N
  );

  modport master (
    output AS, UDS, LDS, RW, A, BGACK, MEM_ACK,
    input  MEM_REQ, MEM_RW, MEM_BE, MEM_ADDR, DATA_OE, DTACK_O, DTACK_OE, BERR_N
  );
endinterface

// File: rtl/zbus_dma_target.sv
// zbus_dma_target: responds to an external Amiga bus master (holding BGACK)
// that accesses accelerator-local memory. Strobes are synchronized, the
// address window is decoded, a req/ack handshake runs towards the local
// memory controller and DTACK is driven back onto the 68000 bus.
//
// Handshake: MEM_REQ rises on the first REQ cycle with MEM_ADDR/MEM_RW/MEM_BE
// already valid and stays high (fields stable) until the cycle in which
// MEM_ACK is sampled high; MEM_ACK is a one-cycle pulse and is ignored
// whenever no request is outstanding.
//
// Optional feature: define DMA_TIMEOUT_BERR_EN to add a request timeout that
// answers with BERR instead of DTACK; without it BERR_N is tied high and a
// request waits for MEM_ACK indefinitely.
module zbus_dma_target #(
  parameter logic [7:0] BASE_ADDR   = 8'h08,
  parameter logic [7:0] BASE_MASK   = 8'hF8,
  parameter int         SYNC_STAGES = 2,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic             CLKCPU,
  input  logic             RESET,
  zbus_dma_target_if.slave bus,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_ABORT   = 3'd2,
    S_ACK     = 3'd3,
    S_RELEASE = 3'd4,
    S_BERR    = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Synchronizer chain, bit order {AS, UDS, LDS, RW, BGACK}; all idle high.
  logic [4:0] r_sync [SYNC_STAGES];

  logic w_as_s;
  logic w_uds_s;
  logic w_lds_s;
  logic w_rw_s;
  logic w_bgack_s;
  logic w_hit;
  logic w_latch;

  logic        r_mem_req;
  logic        r_mem_rw;
  logic [1:0]  r_mem_be;
  logic [23:1] r_mem_addr;
  logic        r_data_oe;
  logic        r_dtack_o;
  logic        r_dtack_oe;

  logic w_mem_req_nxt;
  logic w_data_oe_nxt;
  logic w_dtack_o_nxt;
  logic w_dtack_oe_nxt;

`ifdef DMA_TIMEOUT_BERR_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] r_tmo_cnt;
  logic       r_berr_n;
  logic       w_berr_n_nxt;
`endif

  // Bring the asynchronous bus strobes into the CLKCPU domain.
  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= 5'b11111;
      end
    end else begin
      r_sync[0] <= {bus.AS, bus.UDS, bus.LDS, bus.RW, bus.BGACK};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_as_s    = r_sync[SYNC_STAGES-1][4];
  assign w_uds_s   = r_sync[SYNC_STAGES-1][3];
  assign w_lds_s   = r_sync[SYNC_STAGES-1][2];
  assign w_rw_s    = r_sync[SYNC_STAGES-1][1];
  assign w_bgack_s = r_sync[SYNC_STAGES-1][0];

  // The address is stable while AS is low, so it is decoded unsynchronized.
  assign w_hit = (((bus.A[23:16] ^ BASE_ADDR) & BASE_MASK) == 8'h00);

  // Next-state decode, then the registered output values of that next state.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Writes wait here until the late data strobe arrives.
        if (!w_as_s && !w_bgack_s && w_hit && (!w_uds_s || !w_lds_s)) begin
          w_state_nxt = S_REQ;
          w_latch     = 1'b1;
        end
      end
      S_REQ: begin
        // An ack coinciding with AS rising still completes with DTACK.
        if (bus.MEM_ACK) begin
          w_state_nxt = S_ACK;
        end else if (w_as_s) begin
          w_state_nxt = S_ABORT;
        end
`ifdef DMA_TIMEOUT_BERR_EN
        else if (r_tmo_cnt == TMO_LAST) begin
          w_state_nxt = S_BERR;
        end
`endif
      end
      S_ABORT: begin
        // Memory must still finish the access before the bus is reused.
        if (bus.MEM_ACK) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACK: begin
        if (w_as_s) begin
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // One cycle of active pull-up; a new AS is only looked at from IDLE.
        w_state_nxt = S_IDLE;
      end
      S_BERR: begin
        if (w_as_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_mem_req_nxt  = 1'b0;
    w_data_oe_nxt  = 1'b0;
    w_dtack_o_nxt  = 1'b1;
    w_dtack_oe_nxt = 1'b0;
`ifdef DMA_TIMEOUT_BERR_EN
    w_berr_n_nxt   = 1'b1;
`endif
    case (w_state_nxt)
      S_REQ: begin
        w_mem_req_nxt = 1'b1;
        w_data_oe_nxt = w_latch ? w_rw_s : r_mem_rw;
      end
      S_ABORT: begin
        w_mem_req_nxt = 1'b1;
      end
      S_ACK: begin
        w_data_oe_nxt  = r_mem_rw;
        w_dtack_o_nxt  = 1'b0;
        w_dtack_oe_nxt = 1'b1;
      end
      S_RELEASE: begin
        w_dtack_oe_nxt = 1'b1;
      end
`ifdef DMA_TIMEOUT_BERR_EN
      S_BERR: begin
        w_berr_n_nxt = 1'b0;
      end
`endif
      default: begin
      end
    endcase
  end

  // State register and registered bus/memory outputs.
  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_rw   <= 1'b1;
      r_mem_be   <= 2'b00;
      r_mem_addr <= '0;
      r_data_oe  <= 1'b0;
      r_dtack_o  <= 1'b1;
      r_dtack_oe <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_dtack_o  <= w_dtack_o_nxt;
      r_dtack_oe <= w_dtack_oe_nxt;
      if (w_latch) begin
        r_mem_addr <= bus.A;
        r_mem_rw   <= w_rw_s;
        r_mem_be   <= {~w_uds_s, ~w_lds_s};
      end
    end
  end

`ifdef DMA_TIMEOUT_BERR_EN
  // Count REQ cycles from entry; the state decode compares against the limit.
  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      r_tmo_cnt <= 8'd0;
      r_berr_n  <= 1'b1;
    end else begin
      r_berr_n <= w_berr_n_nxt;
      if (w_latch) begin
        r_tmo_cnt <= 8'd0;
      end else if (r_state == S_REQ) begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end
    end
  end

  assign bus.BERR_N = r_berr_n;
`else
  assign bus.BERR_N = 1'b1;
`endif

  assign bus.MEM_REQ  = r_mem_req;
  assign bus.MEM_RW   = r_mem_rw;
  assign bus.MEM_BE   = r_mem_be;
  assign bus.MEM_ADDR = r_mem_addr;
  assign bus.DATA_OE  = r_data_oe;
  assign bus.DTACK_O  = r_dtack_o;
  assign bus.DTACK_OE = r_dtack_oe;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_zbus_dma_target.sv
// tb_zbus_dma_target: directed bench for zbus_dma_target. Inputs change
// and outputs are sampled 1 ns after the rising edge. Every memory request
// is compared against an expected queue when MEM_REQ rises.
module tb_zbus_dma_target;
  localparam int TMO = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_ABORT   = 3'd2;
  localparam logic [2:0] ST_ACK     = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [25:0] exp_q[$];
  logic       prev_req = 1'b0;

  zbus_dma_target_if bus_if();

  zbus_dma_target #(
    .BASE_ADDR  (8'h08),
    .BASE_MASK  (8'hF8),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .CLKCPU     (clk),
    .RESET      (rst),
    .bus        (bus_if),
    .o_dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_idle();
    bus_if.AS  = 1'b1;
    bus_if.UDS = 1'b1;
    bus_if.LDS = 1'b1;
    bus_if.RW  = 1'b1;
  endtask

  task automatic start_cycle(input logic [23:0] addr, input logic rw,
                             input logic uds_n, input logic lds_n);
    bus_if.A   = addr[23:1];
    bus_if.RW  = rw;
    bus_if.AS  = 1'b0;
    bus_if.UDS = uds_n;
    bus_if.LDS = lds_n;
  endtask

  task automatic expect_req(input logic [23:0] addr, input logic rw, input logic [1:0] be);
    exp_q.push_back({addr[23:1], rw, be});
  endtask

  // Counts ticks until MEM_REQ is seen, bounded.
  task automatic wait_req(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!bus_if.MEM_REQ && lat < 20) begin
      tick();
      lat++;
    end
    chk(tag, lat, exp_lat);
  endtask

  task automatic ack_pulse();
    bus_if.MEM_ACK = 1'b1;
    tick();
    bus_if.MEM_ACK = 1'b0;
  endtask

  // Scoreboard: compare each new request against the expected queue.
  always @(posedge clk) begin
    logic [25:0] e;
    #1;
    if (bus_if.MEM_REQ && !prev_req) begin
      if (exp_q.size() == 0) begin
        chk("req_without_expect", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("req_addr", bus_if.MEM_ADDR, e[25:3]);
        chk("req_rw", bus_if.MEM_RW, e[2]);
        chk("req_be", bus_if.MEM_BE, e[1:0]);
      end
    end
    prev_req = bus_if.MEM_REQ;
  end

  initial begin
    logic sticky;
    logic sticky_drop;
    rst = 1'b1;
    bus_idle();
    bus_if.A       = '0;
    bus_if.BGACK   = 1'b0;
    bus_if.MEM_ACK = 1'b0;
    tick(3);

    // Reset values
    chk("rst_mem_req", bus_if.MEM_REQ, 1'b0);
    chk("rst_mem_rw", bus_if.MEM_RW, 1'b1);
    chk("rst_mem_be", bus_if.MEM_BE, 2'b00);
    chk("rst_mem_addr", bus_if.MEM_ADDR, 23'h0);
    chk("rst_data_oe", bus_if.DATA_OE, 1'b0);
    chk("rst_dtack_o", bus_if.DTACK_O, 1'b1);
    chk("rst_dtack_oe", bus_if.DTACK_OE, 1'b0);
    chk("rst_berr_n", bus_if.BERR_N, 1'b1);
    chk("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    tick(2);

    // T1 read hit, word
    expect_req(24'h080010, 1'b1, 2'b11);
    start_cycle(24'h080010, 1'b1, 1'b0, 1'b0);
    wait_req("t1_req_latency", 3);
    chk("t1_data_oe", bus_if.DATA_OE, 1'b1);
    chk("t1_no_dtack_in_req", bus_if.DTACK_OE, 1'b0);
    chk("t1_state_req", dbg_state, ST_REQ);
    tick(3);
    chk("t1_req_held", bus_if.MEM_REQ, 1'b1);
    ack_pulse();
    chk("t1_dtack_o", bus_if.DTACK_O, 1'b0);
    chk("t1_dtack_oe", bus_if.DTACK_OE, 1'b1);
    chk("t1_req_dropped", bus_if.MEM_REQ, 1'b0);
    chk("t1_data_oe_ack", bus_if.DATA_OE, 1'b1);
    tick(2);
    chk("t1_dtack_hold", bus_if.DTACK_O, 1'b0);
    bus_idle();
    tick(2);
    chk("t1_dtack_until_as_s", bus_if.DTACK_O, 1'b0);
    tick();
    chk("t1_release_state", dbg_state, ST_RELEASE);
    chk("t1_release_dtack_o", bus_if.DTACK_O, 1'b1);
    chk("t1_release_dtack_oe", bus_if.DTACK_OE, 1'b1);
    chk("t1_release_data_oe", bus_if.DATA_OE, 1'b0);
    tick();
    chk("t1_idle_state", dbg_state, ST_IDLE);
    chk("t1_idle_dtack_oe", bus_if.DTACK_OE, 1'b0);

    // T2 write, low byte, LDS arrives late
    expect_req(24'h0A1234, 1'b0, 2'b01);
    start_cycle(24'h0A1234, 1'b0, 1'b1, 1'b1);
    sticky = 1'b0;
    sticky_drop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      sticky = sticky | bus_if.MEM_REQ;
      sticky_drop = sticky_drop | bus_if.DATA_OE;
    end
    chk("t2_no_req_before_ds", sticky, 1'b0);
    bus_if.LDS = 1'b0;
    tick(2);
    chk("t2_req_not_yet", bus_if.MEM_REQ, 1'b0);
    tick();
    chk("t2_req_after_lds", bus_if.MEM_REQ, 1'b1);
    chk("t2_mem_rw", bus_if.MEM_RW, 1'b0);
    sticky_drop = sticky_drop | bus_if.DATA_OE;
    tick(2);
    ack_pulse();
    chk("t2_dtack_o", bus_if.DTACK_O, 1'b0);
    sticky_drop = sticky_drop | bus_if.DATA_OE;
    bus_idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      sticky_drop = sticky_drop | bus_if.DATA_OE;
    end
    chk("t2_data_oe_never", sticky_drop, 1'b0);
    chk("t2_idle_state", dbg_state, ST_IDLE);

    // T3 address miss
    start_cycle(24'h100000, 1'b1, 1'b0, 1'b0);
    sticky = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      sticky = sticky | bus_if.MEM_REQ | bus_if.DTACK_OE | bus_if.DATA_OE;
    end
    chk("t3_miss_quiet", sticky, 1'b0);
    chk("t3_miss_state", dbg_state, ST_IDLE);
    chk("t3_addr_untouched", bus_if.MEM_ADDR, 23'h05091A);
    bus_idle();
    tick(3);

    // T3 hit while the external master does not own the bus
    bus_if.BGACK = 1'b1;
    tick(3);
    start_cycle(24'h080020, 1'b1, 1'b0, 1'b0);
    sticky = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      sticky = sticky | bus_if.MEM_REQ | bus_if.DTACK_OE | bus_if.DATA_OE;
    end
    chk("t3_not_owner_quiet", sticky, 1'b0);
    bus_idle();
    bus_if.BGACK = 1'b0;
    tick(3);

    // Stray MEM_ACK while idle
    ack_pulse();
    tick();
    chk("stray_ack_state", dbg_state, ST_IDLE);
    chk("stray_ack_dtack_oe", bus_if.DTACK_OE, 1'b0);

    // T4 abort: AS rises before the memory acknowledges
    expect_req(24'h080100, 1'b1, 2'b10);
    start_cycle(24'h080100, 1'b1, 1'b0, 1'b1);
    wait_req("t4_req_latency", 3);
    tick(2);
    bus_idle();
    sticky = 1'b0;
    sticky_drop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      sticky = sticky | bus_if.DTACK_OE;
      sticky_drop = sticky_drop | ~bus_if.MEM_REQ;
    end
    chk("t4_abort_state", dbg_state, ST_ABORT);
    chk("t4_req_held", sticky_drop, 1'b0);
    ack_pulse();
    chk("t4_idle_after_ack", dbg_state, ST_IDLE);
    chk("t4_req_low", bus_if.MEM_REQ, 1'b0);
    chk("t4_no_dtack", sticky | bus_if.DTACK_OE, 1'b0);

    // MEM_ACK in the same cycle AS is seen rising
    expect_req(24'h08FFFE, 1'b1, 2'b11);
    start_cycle(24'h08FFFE, 1'b1, 1'b0, 1'b0);
    wait_req("race_req_latency", 3);
    bus_idle();
    tick(2);
    chk("race_still_req", dbg_state, ST_REQ);
    ack_pulse();
    chk("race_ack_state", dbg_state, ST_ACK);
    chk("race_dtack_o", bus_if.DTACK_O, 1'b0);
    tick();
    chk("race_release_state", dbg_state, ST_RELEASE);
    tick();
    chk("race_idle_state", dbg_state, ST_IDLE);

    // Back-to-back: AS low again during RELEASE starts from IDLE a cycle later
    expect_req(24'h080200, 1'b1, 2'b11);
    expect_req(24'h080202, 1'b1, 2'b11);
    start_cycle(24'h080200, 1'b1, 1'b0, 1'b0);
    wait_req("b2b_first_latency", 3);
    ack_pulse();
    bus_idle();
    tick();
    start_cycle(24'h080202, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b_ack_state", dbg_state, ST_ACK);
    tick();
    chk("b2b_release_state", dbg_state, ST_RELEASE);
    tick();
    chk("b2b_idle_state", dbg_state, ST_IDLE);
    chk("b2b_not_taken_in_release", bus_if.MEM_REQ, 1'b0);
    tick();
    chk("b2b_second_req", bus_if.MEM_REQ, 1'b1);
    chk("b2b_second_state", dbg_state, ST_REQ);
    ack_pulse();
    bus_idle();
    tick(4);

    // T5 reset while DTACK is asserted
    expect_req(24'h0BFFF0, 1'b1, 2'b11);
    start_cycle(24'h0BFFF0, 1'b1, 1'b0, 1'b0);
    wait_req("t5_req_latency", 3);
    ack_pulse();
    chk("t5_dtack_before_rst", bus_if.DTACK_O, 1'b0);
    rst = 1'b1;
    bus_idle();
    tick();
    chk("t5_mem_req", bus_if.MEM_REQ, 1'b0);
    chk("t5_mem_rw", bus_if.MEM_RW, 1'b1);
    chk("t5_mem_be", bus_if.MEM_BE, 2'b00);
    chk("t5_mem_addr", bus_if.MEM_ADDR, 23'h0);
    chk("t5_data_oe", bus_if.DATA_OE, 1'b0);
    chk("t5_dtack_o", bus_if.DTACK_O, 1'b1);
    chk("t5_dtack_oe", bus_if.DTACK_OE, 1'b0);
    chk("t5_berr_n", bus_if.BERR_N, 1'b1);
    chk("t5_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    tick(3);
    chk("t5_stays_idle", dbg_state, ST_IDLE);

`ifdef DMA_TIMEOUT_BERR_EN
    // T6 timeout answers with BERR
    expect_req(24'h080300, 1'b1, 2'b11);
    start_cycle(24'h080300, 1'b1, 1'b0, 1'b0);
    wait_req("t6_req_latency", 3);
    tick(15);
    chk("t6_req_before_tmo", bus_if.MEM_REQ, 1'b1);
    chk("t6_berr_n_before_tmo", bus_if.BERR_N, 1'b1);
    tick();
    chk("t6_berr_n", bus_if.BERR_N, 1'b0);
    chk("t6_req_dropped", bus_if.MEM_REQ, 1'b0);
    chk("t6_dtack_oe", bus_if.DTACK_OE, 1'b0);
    chk("t6_berr_state", dbg_state, 3'd5);
    ack_pulse();
    chk("t6_late_ack_state", dbg_state, 3'd5);
    chk("t6_late_ack_dtack", bus_if.DTACK_OE, 1'b0);
    bus_idle();
    tick(3);
    chk("t6_berr_released", bus_if.BERR_N, 1'b1);
    chk("t6_idle_state", dbg_state, ST_IDLE);
`else
    // Without the timeout a request waits for MEM_ACK indefinitely
    expect_req(24'h080300, 1'b1, 2'b11);
    start_cycle(24'h080300, 1'b1, 1'b0, 1'b0);
    wait_req("t6_req_latency", 3);
    tick(40);
    chk("t6_req_waits", bus_if.MEM_REQ, 1'b1);
    chk("t6_state_req", dbg_state, ST_REQ);
    chk("t6_berr_n_tied", bus_if.BERR_N, 1'b1);
    ack_pulse();
    chk("t6_ack_state", dbg_state, ST_ACK);
    bus_idle();
    tick(4);
    chk("t6_idle_state", dbg_state, ST_IDLE);
`endif

    chk("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
